// File: rtl/serializer_vc_scheduler.sv
// Round-robin, credit-gated virtual-channel scheduler feeding a shared flit serializer.
// One flit is launched per serializer occupancy window; per-VC downstream credits are tracked locally.
module serializer_vc_scheduler #(
    parameter int unsigned CREDITS    = 4,
    parameter int unsigned SER_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [255:0] req_data,
    input  logic [3:0]   credit_ret,
    output logic [3:0]   grant,
    output logic [63:0]  ser_data,
    output logic         ser_valid,
    output logic [1:0]   ser_vc,
    output logic         busy,
    output logic         cred_err
);

    localparam int unsigned CW          = $clog2(CREDITS + 1);
    localparam int unsigned HOLD_CYCLES = (SER_CYCLES > 2) ? SER_CYCLES - 2 : 1;
    localparam int unsigned HW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;

    state_t          state;
    logic [1:0]      rr_ptr;
    logic [HW-1:0]   hold_cnt;
    logic [CW-1:0]   credit [4];
    logic [3:0]      eligible;
    logic            found;
    logic [1:0]      winner;
    logic [1:0]      arb_idx;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = req[i] && (credit[i] != '0);
        end
    end

    // Round-robin search starting at rr_ptr, wrapping 3 -> 0.
    always_comb begin
        found   = 1'b0;
        winner  = rr_ptr;
        arb_idx = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            arb_idx = rr_ptr + 2'(k);
            if (!found && eligible[arb_idx]) begin
                found  = 1'b1;
                winner = arb_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            grant     <= '0;
            ser_data  <= '0;
            ser_valid <= 1'b0;
            ser_vc    <= '0;
            busy      <= 1'b0;
            cred_err  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                credit[i] <= CRED_MAX;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= LAUNCH;
                        ser_valid <= 1'b1;
                        grant     <= 4'b0001 << winner;
                        ser_data  <= req_data[{winner, 6'd0} +: 64];
                        ser_vc    <= winner;
                        rr_ptr    <= winner + 2'd1;
                    end
                end
                LAUNCH: begin
                    ser_valid <= 1'b0;
                    grant     <= '0;
                    hold_cnt  <= '0;
                    state     <= (SER_CYCLES > 2) ? HOLD : IDLE;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Covers the serializer's full occupancy: the first IDLE cycle after HOLD is its last busy cycle.
            busy <= (state != IDLE) || found;

            // Credits keep counting in every state; a return at full credit saturates and flags.
            for (int i = 0; i < 4; i++) begin
                case ({grant[i], credit_ret[i]})
                    2'b10: credit[i] <= credit[i] - CW'(1);
                    2'b01: begin
                        if (credit[i] == CRED_MAX) begin
                            cred_err <= 1'b1;
                        end else begin
                            credit[i] <= credit[i] + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
